// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared widths, types and reset values for the 4-to-16 decoder
// Purpose: constants and types shared by decoder_3x8 and decoder_4x16.
// Ports:   none (package).
package decoder_pkg;

    localparam int DEC_IN_W  = 4;
    localparam int DEC_OUT_W = 16;
    localparam int SUB_IN_W  = 3;
    localparam int SUB_OUT_W = 8;

    typedef logic [DEC_IN_W-1:0]  dec_idx_t;
    typedef logic [DEC_OUT_W-1:0] dec_onehot_t;

    localparam dec_onehot_t DEC_Y_RST = 16'h0000;

    // Active-low copy resets to the complement of the active-high reset value.
    localparam dec_onehot_t DEC_Y_N_RST = ~DEC_Y_RST;

endpackage

// File: rtl/decoder_3x8.sv
// rtl/decoder_3x8.sv - combinational 3-to-8 one-hot decoder with enable
// Purpose: one half of the 4-to-16 decode; y is all-zero when en is low.
// Ports:
//   en  input  1  sub-decoder enable
//   a   input  3  binary index
//   y   output 8  one-hot decode of a, or zero when disabled
module decoder_3x8
    import decoder_pkg::*;
(
    input  logic                 en,
    input  logic [SUB_IN_W-1:0]  a,
    output logic [SUB_OUT_W-1:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[a] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_4x16.sv
// rtl/decoder_4x16.sv - registered 4-to-16 one-hot decoder built from two 3-to-8 halves
// Purpose: a[3] steers the enable to either the low or high 3-to-8 decoder; the
//          combined 16-bit result is registered, giving one clock of latency and
//          no combinational path from inputs to outputs.
// Optional: define DECODER_4X16_ACTIVE_LOW_EN to add the registered y_n = ~y output.
// Ports:
//   clk      input  1   rising-edge clock
//   rst      input  1   asynchronous active-high reset
//   en       input  1   decode enable, sampled on clk
//   a        input  4   binary index to decode
//   y        output 16  registered one-hot decode (zero when en was low)
//   y_valid  output 1   high when y holds a decode of an enabled sample
//   y_n      output 16  registered ~y (only with DECODER_4X16_ACTIVE_LOW_EN)
module decoder_4x16
    import decoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  dec_idx_t    a,
    output dec_onehot_t y,
`ifdef DECODER_4X16_ACTIVE_LOW_EN
    output logic        y_valid,
    output dec_onehot_t y_n
`else
    output logic        y_valid
`endif
);

    logic                 en_lo;
    logic                 en_hi;
    logic [SUB_OUT_W-1:0] y_lo;
    logic [SUB_OUT_W-1:0] y_hi;
    dec_onehot_t          y_next;

    // At most one half is enabled, so y_next is zero or one-hot by construction.
    assign en_lo = en & ~a[DEC_IN_W-1];
    assign en_hi = en &  a[DEC_IN_W-1];

    decoder_3x8 u_dec_lo (
        .en (en_lo),
        .a  (a[SUB_IN_W-1:0]),
        .y  (y_lo)
    );

    decoder_3x8 u_dec_hi (
        .en (en_hi),
        .a  (a[SUB_IN_W-1:0]),
        .y  (y_hi)
    );

    assign y_next = {y_hi, y_lo};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y       <= DEC_Y_RST;
            y_valid <= 1'b0;
        end else begin
            y       <= y_next;
            y_valid <= en;
        end
    end

`ifdef DECODER_4X16_ACTIVE_LOW_EN
    // Separate register fed from y_next so y_n changes on the same edge as y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_n <= DEC_Y_N_RST;
        end else begin
            y_n <= ~y_next;
        end
    end
`endif

endmodule

// File: tb/tb_decoder_4x16.sv
// tb/tb_decoder_4x16.sv - self-checking bench for decoder_4x16
module tb_decoder_4x16;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  a;
    logic [15:0] y;
    logic        y_valid;
`ifdef DECODER_4X16_ACTIVE_LOW_EN
    logic [15:0] y_n;
`endif

    int checks;
    int failures;

    decoder_4x16 dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .a       (a),
        .y       (y),
`ifdef DECODER_4X16_ACTIVE_LOW_EN
        .y_valid (y_valid),
        .y_n     (y_n)
`else
        .y_valid (y_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: bit i is set exactly when the sample was enabled and its index equals i.
    function automatic logic [15:0] ref_y(input logic e, input logic [3:0] idx);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[i] = e && (int'(idx) == i);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic e, input logic [3:0] idx);
        check({tag, ".y"}, 32'(y), 32'(ref_y(e, idx)));
        check({tag, ".y_valid"}, 32'(y_valid), 32'(e));
`ifdef DECODER_4X16_ACTIVE_LOW_EN
        check({tag, ".y_n"}, 32'(y_n), 32'(~ref_y(e, idx)));
`endif
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".y"}, 32'(y), 32'h0000);
        check({tag, ".y_valid"}, 32'(y_valid), 32'h0);
`ifdef DECODER_4X16_ACTIVE_LOW_EN
        check({tag, ".y_n"}, 32'(y_n), 32'hFFFF);
`endif
    endtask

    // Drive (e, idx), let one rising edge sample it, then check 1 ns later.
    task automatic step(input string tag, input logic e, input logic [3:0] idx);
        en = e;
        a  = idx;
        @(posedge clk);
        #1;
        check_outputs(tag, e, idx);
    endtask

    initial begin
        logic        prev_en;
        logic [3:0]  prev_a;
        logic        inv_ok;

        checks   = 0;
        failures = 0;
        rst = 1'b1;
        en  = 1'b1;
        a   = 4'h5;

        // Reset held across an edge: outputs stay cleared.
        #3;
        check_reset_state("reset_initial");
        @(posedge clk);
        #1;
        check_reset_state("reset_held");

        // First edge after release loads normally.
        #2;
        rst = 1'b0;
        step("post_reset_a5", 1'b1, 4'h5);
        check("post_reset_a5.lit", 32'(y), 32'h0020);

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("async_reset");
        #1;
        rst = 1'b0;
        #1;
        check_reset_state("async_reset_released_no_edge");
        step("after_async_reset", 1'b1, 4'h5);
        check("after_async_reset.lit", 32'(y), 32'h0020);

        // Exhaustive sweep on consecutive edges.
        for (int i = 0; i < 16; i++) begin
            step($sformatf("sweep_a%0d", i), 1'b1, 4'(i));
            if (i == 0)  check("sweep_lit_a0",  32'(y), 32'h0001);
            if (i == 3)  check("sweep_lit_a3",  32'(y), 32'h0008);
            if (i == 8)  check("sweep_lit_a8",  32'(y), 32'h0100);
            if (i == 15) check("sweep_lit_a15", 32'(y), 32'h8000);
        end

        // Crossing between halves; inputs changed between edges must not reach y.
        step("cross_a7", 1'b1, 4'h7);
        check("cross_a7.lit", 32'(y), 32'h0080);
        a = 4'h8;
        #2;
        check("no_comb_path", 32'(y), 32'h0080);
        step("cross_a8", 1'b1, 4'h8);
        check("cross_a8.lit", 32'(y), 32'h0100);
        check("cross_a8.popcount", 32'($countones(y)), 32'd1);

        // Enable gating.
        step("gated_aA", 1'b0, 4'hA);
        check("gated_aA.lit", 32'(y), 32'h0000);
        step("reenable_aA", 1'b1, 4'hA);
        check("reenable_aA.lit", 32'(y), 32'h0400);

        step("a2", 1'b1, 4'h2);
        check("a2.lit", 32'(y), 32'h0004);
`ifdef DECODER_4X16_ACTIVE_LOW_EN
        check("a2.y_n_lit", 32'(y_n), 32'hFFFB);
`endif

        // Random run: model match plus the output invariant.
        for (int n = 0; n < 1000; n++) begin
            prev_en = ($urandom_range(0, 3) != 0);
            prev_a  = 4'($urandom);
            en = prev_en;
            a  = prev_a;
            @(posedge clk);
            #1;
            check_outputs("random", prev_en, prev_a);
            inv_ok = y_valid ? ($countones(y) == 1) : (y == 16'h0000);
            check("random.invariant", 32'(inv_ok), 32'h1);
            // Scramble inputs between edges to expose any combinational leak.
            a  = 4'($urandom);
            en = $urandom_range(0, 1) != 0;
            #2;
            check("random.hold", 32'(y), 32'(ref_y(prev_en, prev_a)));
        end

        // Reset mid-stream has priority over en and a.
        en = 1'b1;
        a  = 4'hF;
        #1;
        rst = 1'b1;
        #1;
        check_reset_state("midstream_reset");
        @(posedge clk);
        #1;
        check_reset_state("midstream_reset_edge");
        rst = 1'b0;
        step("final_aF", 1'b1, 4'hF);
        check("final_aF.lit", 32'(y), 32'h8000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
